// File: rtl/adder_err_pkg.sv
// adder_err_pkg
//   Shared definitions for the adder error monitor: default widths and the
//   run-control state encoding.
//   No ports; imported by the monitor top and its sub-modules.
package adder_err_pkg;

  localparam int DEF_WIDTH = 16;   // operand width; results are DEF_WIDTH+1 bits
  localparam int DEF_CNT_W = 16;   // sample/error counter width
  localparam int DEF_ACC_W = 40;   // error-distance accumulator width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/err_distance_calc.sv
// err_distance_calc
//   Purely combinational absolute difference between an exact reference value
//   and an approximate value. Shared by the adder and multiplier monitors.
//   Ports:
//     exact_i  - exact reference value (unsigned, W bits)
//     approx_i - value produced by the unit under test (unsigned, W bits)
//     dist_o   - |exact_i - approx_i|, W bits, no sign kept
module err_distance_calc #(
  parameter int W = 17
) (
  input  logic [W-1:0] exact_i,
  input  logic [W-1:0] approx_i,
  output logic [W-1:0] dist_o
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    if (exact_i >= approx_i) begin
      dist_o = exact_i - approx_i;
    end else begin
      dist_o = approx_i - exact_i;
    end
  end

endmodule

// File: rtl/adder_error_monitor16.sv
// adder_error_monitor16
//   Grades an adder under test against exact addition. Each accepted sample
//   (operands plus the adder's result) flows through a 3-stage pipeline:
//     S1: exact sum, captured result, accept flag
//     S2: error distance
//     S3: metric update (sample count, error count, max ED, saturating sum ED)
//   A sample accepted at edge N is reflected in the outputs after edge N+2.
//
//   Ports:
//     clk_i          - clock, rising edge
//     rst_i          - asynchronous reset, active high
//     start_i        - pulse: clear metrics, latch num_samples_i, start a run
//     num_samples_i  - number of samples to collect in the run
//     valid_i        - add1_i/add2_i/result_i valid this cycle
//     add1_i, add2_i - operands fed to the adder under test
//     result_i       - adder-under-test result (WIDTH+1 bits)
//     busy_o         - run or drain in progress
//     done_o         - metrics final; held until the next start or reset
//     sample_cnt_o   - samples accumulated
//     err_cnt_o      - samples with nonzero error distance
//     max_ed_o       - largest error distance seen
//     sum_ed_o       - sum of error distances, saturating at all-ones
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset; waiting for start_i
//   RUN   | accepting samples until the remaining count reaches zero
//   DRAIN | last sample accepted; waiting for S1/S2 to empty
//   DONE  | metrics final and held; start_i begins a new run
module adder_error_monitor16
  import adder_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   num_samples_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   add1_i,
  input  logic [WIDTH-1:0]   add2_i,
  input  logic [WIDTH:0]     result_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   sample_cnt_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic [WIDTH:0]     max_ed_o,
  output logic [ACC_W-1:0]   sum_ed_o
);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             start_ok;
  logic             accept;

  // S1
  logic [WIDTH:0]   exact_sum;
  logic             acc1_q;
  logic [WIDTH:0]   exact1_q;
  logic [WIDTH:0]   res1_q;

  // S2
  logic [WIDTH:0]   ed;
  logic             acc2_q;
  logic [WIDTH:0]   ed2_q;

  // S3 metrics
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH:0]   max_ed_q, max_ed_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [ACC_W:0]   sum_ext;

  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // A start is honoured only when no run is in flight; a valid arriving in
  // the same cycle as the start is dropped because the state is not yet RUN.
  assign start_ok  = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign accept    = valid_i && (state_q == RUN) && (remaining_q != '0);
  assign exact_sum = {1'b0, add1_i} + {1'b0, add2_i};

  err_distance_calc #(
    .W (WIDTH + 1)
  ) u_ed (
    .exact_i  (exact1_q),
    .approx_i (res1_q),
    .dist_o   (ed)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          remaining_d = num_samples_i;
          state_d     = (num_samples_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Once neither in-flight stage holds a sample, S3 has absorbed the
        // last one and the metrics are final.
        if (!acc1_q && !acc2_q) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    max_ed_d     = max_ed_q;
    sum_ed_d     = sum_ed_q;
    // One extra bit catches the carry out; any carry means the true sum no
    // longer fits, so the accumulator pins at all-ones and stays there.
    sum_ext      = {1'b0, sum_ed_q} + {{(ACC_W - WIDTH){1'b0}}, ed2_q};
    if (start_ok) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      max_ed_d     = '0;
      sum_ed_d     = '0;
    end else if (acc2_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (ed2_q != '0) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (ed2_q > max_ed_q) begin
        max_ed_d = ed2_q;
      end
      sum_ed_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      acc1_q       <= 1'b0;
      exact1_q     <= '0;
      res1_q       <= '0;
      acc2_q       <= 1'b0;
      ed2_q        <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      acc1_q       <= accept;
      exact1_q     <= exact_sum;
      res1_q       <= result_i;
      acc2_q       <= acc1_q;
      ed2_q        <= ed;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_ed_q     <= max_ed_d;
      sum_ed_q     <= sum_ed_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sample_cnt_o = sample_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign max_ed_o     = max_ed_q;
  assign sum_ed_o     = sum_ed_q;

endmodule

// File: tb/tb_adder_error_monitor16.sv
module tb_adder_error_monitor16;

  localparam int W     = 16;
  localparam int CW    = 16;
  localparam int AW    = 40;
  localparam int AWS   = 18;
  localparam int NEVER = 32'h3fff_ffff;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [CW-1:0] num   = '0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic [W:0]    r     = '0;

  logic          busy, done;
  logic [CW-1:0] scnt, ecnt;
  logic [W:0]    maxed;
  logic [AW-1:0] sumed;

  logic           busy_s, done_s;
  logic [CW-1:0]  scnt_s, ecnt_s;
  logic [W:0]     maxed_s;
  logic [AWS-1:0] sumed_s;

  always #5 clk = ~clk;

  adder_error_monitor16 #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_samples_i(num),
    .valid_i(valid), .add1_i(a), .add2_i(b), .result_i(r),
    .busy_o(busy), .done_o(done), .sample_cnt_o(scnt), .err_cnt_o(ecnt),
    .max_ed_o(maxed), .sum_ed_o(sumed)
  );

  adder_error_monitor16 #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_samples_i(num),
    .valid_i(valid), .add1_i(a), .add2_i(b), .result_i(r),
    .busy_o(busy_s), .done_o(done_s), .sample_cnt_o(scnt_s), .err_cnt_o(ecnt_s),
    .max_ed_o(maxed_s), .sum_ed_o(sumed_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a run is "in flight" from the start edge until the edge
  // at which done is due; accepted samples are recorded with their edge number
  // and show up in the metrics two edges later.
  int          edge_n    = 0;
  bit          m_started = 0;
  int          done_edge = 0;
  int          m_left    = 0;
  int          last_acc  = 0;
  int          acc_edge_q[$];
  int unsigned acc_ed_q[$];

  function automatic int unsigned ed_of(logic [W-1:0] x, logic [W-1:0] y, logic [W:0] res);
    int d;
    d = int'(x) + int'(y) - int'(res);
    return (d < 0) ? -d : d;
  endfunction

  function automatic bit m_busy_at(int e);
    return m_started && (e < done_edge);
  endfunction

  function automatic bit m_done_at(int e);
    return m_started && (e >= done_edge);
  endfunction

  function automatic void model_metrics(input int aw, output int unsigned sc, output int unsigned ec,
                                        output int unsigned mx, output longint sm);
    longint cap;
    cap = (longint'(1) << aw) - 1;
    sc = 0; ec = 0; mx = 0; sm = 0;
    foreach (acc_edge_q[i]) begin
      if (acc_edge_q[i] + 2 <= edge_n) begin
        sc++;
        if (acc_ed_q[i] != 0) ec++;
        if (acc_ed_q[i] > mx) mx = acc_ed_q[i];
        sm += longint'(acc_ed_q[i]);
        if (sm > cap) sm = cap;
      end
    end
  endfunction

  function automatic void model_reset();
    m_started = 0;
    done_edge = 0;
    m_left    = 0;
    acc_edge_q.delete();
    acc_ed_q.delete();
  endfunction

  // Drive one cycle of stimulus, advance the model, return 1 ns after the edge.
  task automatic step(input logic s, input logic [CW-1:0] n, input logic v,
                      input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] res);
    int e;
    @(negedge clk);
    start = s; num = n; valid = v; a = x; b = y; r = res;
    e = edge_n + 1;
    if (s && !m_busy_at(e - 1)) begin
      acc_edge_q.delete();
      acc_ed_q.delete();
      m_started = 1;
      m_left    = int'(n);
      done_edge = (n == '0) ? e : NEVER;
    end else if (v && m_busy_at(e - 1) && m_left > 0) begin
      acc_edge_q.push_back(e);
      acc_ed_q.push_back(ed_of(x, y, res));
      m_left--;
      last_acc = e;
      if (m_left == 0) done_edge = e + 3;
    end
    @(posedge clk);
    #1;
    edge_n = e;
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, 16'($urandom), 16'($urandom), 17'($urandom));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) idle_step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); valid = 1'($urandom); num = 16'($urandom);
      a = 16'($urandom); b = 16'($urandom); r = 17'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if ({busy, done, scnt, ecnt, maxed, sumed} !== '0)
      begin n_fail++; $display("FAIL reset_main: got busy=%0b done=%0b sc=%0d ec=%0d max=%0h sum=%0h want all 0", busy, done, scnt, ecnt, maxed, sumed); end
    n_checks++;
    if ({busy_s, done_s, scnt_s, ecnt_s, maxed_s, sumed_s} !== '0)
      begin n_fail++; $display("FAIL reset_sat: got busy=%0b done=%0b sum=%0h want all 0", busy_s, done_s, sumed_s); end
    start = 1'b0; valid = 1'b0; num = '0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_exact();
    int unsigned sc, ec, mx; longint sm;
    step(1'b1, 16'd2, 1'b0, '0, '0, '0);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      begin n_fail++; $display("FAIL exact_busy: got busy=%0b done=%0b want busy=1 done=0", busy, done); end
    step(1'b0, '0, 1'b1, 16'h29AF, 16'h7A1B, 17'h0A3CA);
    step(1'b0, '0, 1'b1, 16'h8943, 16'hFFFF, 17'h18942);
    wait_done(20);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL exact_done: got done=%0b busy=%0b want done=1 busy=0", done, busy); end
    n_checks++;
    if (scnt !== 16'd2 || ecnt !== 16'd0 || maxed !== 17'h0 || sumed !== 40'h0)
      begin n_fail++; $display("FAIL exact_metrics: got sc=%0d ec=%0d max=%0h sum=%0h want 2 0 0 0", scnt, ecnt, maxed, sumed); end
    model_metrics(AW, sc, ec, mx, sm);
    n_checks++;
    if (scnt !== CW'(sc) || ecnt !== CW'(ec) || maxed !== 17'(mx) || sumed !== AW'(sm))
      begin n_fail++; $display("FAIL exact_model: got sc=%0d ec=%0d max=%0h sum=%0h want %0d %0d %0h %0h", scnt, ecnt, maxed, sumed, sc, ec, mx, sm); end
  endtask

  task automatic test_approx();
    step(1'b1, 16'd2, 1'b0, '0, '0, '0);
    step(1'b0, '0, 1'b1, 16'h5555, 16'hAAAA, 17'h0FFF0);
    step(1'b0, '0, 1'b1, 16'h8051, 16'h8086, 17'h100E0);
    wait_done(20);
    n_checks++;
    if (done !== 1'b1 || scnt !== 16'd2 || ecnt !== 16'd2 || maxed !== 17'h0F || sumed !== 40'h18)
      begin n_fail++; $display("FAIL approx_metrics: got done=%0b sc=%0d ec=%0d max=%0h sum=%0h want 1 2 2 f 18", done, scnt, ecnt, maxed, sumed); end
  endtask

  task automatic test_gaps();
    int first_done;
    first_done = -1;
    step(1'b1, 16'd3, 1'b0, '0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      step(k == 5, 16'd9, (k % 2) == 0, 16'($urandom), 16'($urandom), 17'($urandom));
      if (done === 1'b1 && first_done < 0) first_done = edge_n;
    end
    n_checks++;
    if (first_done !== last_acc + 3)
      begin n_fail++; $display("FAIL gaps_done_latency: got done edge %0d want %0d", first_done, last_acc + 3); end
    n_checks++;
    if (scnt !== 16'd3 || done !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL gaps_count: got sc=%0d done=%0b busy=%0b want 3 1 0", scnt, done, busy); end
  endtask

  task automatic test_zero_restart();
    int unsigned sc, ec, mx; longint sm;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    step(1'b1, 16'd0, 1'b0, '0, '0, '0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {scnt, ecnt, maxed, sumed} !== '0)
      begin n_fail++; $display("FAIL zero_from_idle: got done=%0b busy=%0b sc=%0d sum=%0h want 1 0 0 0", done, busy, scnt, sumed); end
    step(1'b1, 16'd1, 1'b0, '0, '0, '0);
    step(1'b0, '0, 1'b1, 16'h1234, 16'h0001, 17'h01200);
    wait_done(20);
    model_metrics(AW, sc, ec, mx, sm);
    n_checks++;
    if (done !== 1'b1 || scnt !== CW'(sc) || ecnt !== CW'(ec) || maxed !== 17'(mx) || sumed !== AW'(sm) || sumed !== 40'h35)
      begin n_fail++; $display("FAIL zero_one_sample: got sc=%0d ec=%0d max=%0h sum=%0h want %0d %0d %0h %0h", scnt, ecnt, maxed, sumed, sc, ec, mx, sm); end
    step(1'b1, 16'd0, 1'b0, '0, '0, '0);
    n_checks++;
    if (done !== 1'b1 || {scnt, ecnt, maxed, sumed} !== '0)
      begin n_fail++; $display("FAIL zero_restart_clear: got done=%0b sc=%0d ec=%0d max=%0h sum=%0h want 1 0 0 0 0", done, scnt, ecnt, maxed, sumed); end
  endtask

  task automatic test_random();
    int unsigned sc, ec, mx; longint sm;
    logic [W-1:0] x, y;
    logic [W:0]   res, ex;
    int n;
    for (int run = 0; run < 6; run++) begin
      n = $urandom_range(1, 20);
      x = 16'($urandom); y = 16'($urandom);
      // valid together with start must be dropped
      step(1'b1, CW'(n), 1'b1, x, y, 17'($urandom));
      for (int i = 0; i < 200 && done !== 1'b1; i++) begin
        x = 16'($urandom); y = 16'($urandom);
        ex = {1'b0, x} + {1'b0, y};
        case ($urandom_range(0, 2))
          0:       res = ex;
          1:       res = ex ^ 17'($urandom_range(1, 255));
          default: res = 17'($urandom);
        endcase
        step((($urandom % 8) == 0) && m_busy_at(edge_n), CW'($urandom_range(0, 30)),
             ($urandom % 3) != 0, x, y, res);
        model_metrics(AW, sc, ec, mx, sm);
        n_checks++;
        if (busy !== m_busy_at(edge_n) || done !== m_done_at(edge_n) ||
            scnt !== CW'(sc) || ecnt !== CW'(ec) || maxed !== 17'(mx) || sumed !== AW'(sm))
          begin n_fail++; $display("FAIL random_cycle run%0d: got busy=%0b done=%0b sc=%0d ec=%0d max=%0h sum=%0h want %0b %0b %0d %0d %0h %0h",
                                   run, busy, done, scnt, ecnt, maxed, sumed, m_busy_at(edge_n), m_done_at(edge_n), sc, ec, mx, sm); end
      end
      n_checks++;
      if (done !== 1'b1 || scnt !== CW'(n))
        begin n_fail++; $display("FAIL random_final run%0d: got done=%0b sc=%0d want 1 %0d", run, done, scnt, n); end
    end
  endtask

  task automatic test_saturation();
    int unsigned sc, ec, mx; longint sm;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    step(1'b1, 16'd3, 1'b0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, i < 3, 16'h0000, 16'h0000, 17'h1FFFF);
      model_metrics(AWS, sc, ec, mx, sm);
      n_checks++;
      if (sumed_s !== AWS'(sm) || maxed_s !== 17'(mx) || ecnt_s !== CW'(ec))
        begin n_fail++; $display("FAIL sat_cycle %0d: got sum=%0h max=%0h ec=%0d want %0h %0h %0d", i, sumed_s, maxed_s, ecnt_s, sm, mx, ec); end
    end
    n_checks++;
    if (done_s !== 1'b1 || sumed_s !== 18'h3FFFF || maxed_s !== 17'h1FFFF || ecnt_s !== 16'd3)
      begin n_fail++; $display("FAIL sat_final: got done=%0b sum=%0h max=%0h ec=%0d want 1 3ffff 1ffff 3", done_s, sumed_s, maxed_s, ecnt_s); end
    n_checks++;
    if (sumed !== 40'h5FFFD)
      begin n_fail++; $display("FAIL sat_wide_sum: got %0h want 5fffd", sumed); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    step(1'b1, 16'd10, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 16'h00FF, 16'h0001, 17'h00000);
    n_checks++;
    if (busy !== 1'b1 || scnt !== 16'd2 || sumed !== 40'h200)
      begin n_fail++; $display("FAIL async_pre: got busy=%0b sc=%0d sum=%0h want 1 2 200", busy, scnt, sumed); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, scnt, ecnt, maxed, sumed} !== '0 || {busy_s, done_s, scnt_s, sumed_s} !== '0)
      begin n_fail++; $display("FAIL async_immediate: got busy=%0b sc=%0d sum=%0h sat_sum=%0h want all 0", busy, scnt, sumed, sumed_s); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 16'h00FF, 16'h0001, 17'h00000);
    n_checks++;
    if ({busy, done, scnt, ecnt, maxed, sumed} !== '0)
      begin n_fail++; $display("FAIL async_after: got busy=%0b done=%0b sc=%0d sum=%0h want all 0", busy, done, scnt, sumed); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_gaps();
    test_zero_restart();
    test_random();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
